spi_slave_counter_rx: RTL and testbench
=======================================

Name: spi_slave_counter_rx

Overview:
SPI slave receiver for the counter link. It sits on the far side of the SPI bus from the counter master and consumes its 2-byte, SS-framed transactions: a high byte {2'b00, cnt[13:8]} followed by a low byte cnt[7:0]. It reassembles the 14-bit counter value, checks the frame, and presents the value to the FND display path with a one-cycle valid strobe. MISO returns the previously committed value as a loopback for the master to read back.

Parameters:
SYNC_STAGES, 2, flop depth of the sclk/mosi/ss input synchronizers (min 2)
CNT_W, 14, width of reassembled counter; fixed 14 for this frame format

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
sclk  input  1  SPI clock from master, mode 0, async to clk
mosi  input  1  SPI data from master, MSB first
ss  input  1  slave select, active low, async to clk
miso  output  1  loopback data to master, MSB first
o_counter  output  14  last committed counter value
o_valid  output  1  one-cycle pulse when o_counter updates
o_frame_err  output  1  one-cycle pulse on rejected frame
o_busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset is asynchronous, active-high; clock is clk. On reset: o_counter=0, o_valid=0, o_frame_err=0, o_busy=0, miso=0, FSM=IDLE, armed=0. Synchronizer flops reset to sclk=0, mosi=0, ss=1.
- All of sclk, mosi, and ss pass through SYNC_STAGES flops. Edges are detected on the synchronized signals against a one-cycle-delayed copy. The sclk half-period must be >= 4 clk cycles.
- armed: set the first cycle synced ss=1. No frame starts while armed=0. A master still holding ss low across reset release is therefore ignored until ss goes high.
- FSM states: IDLE, RX_HIGH, RX_LOW, WAIT_SS.
  - IDLE -> RX_HIGH on synced ss falling edge with armed=1. Clears bit_cnt, overrun, and pad_err. Loads tx_shift={2'b00,o_counter[13:8]}. miso=tx_shift[7] from this cycle on.
  - In RX_HIGH/RX_LOW, each synced sclk rising edge: rx_shift={rx_shift[6:0],mosi_sync}, bit_cnt+1 (3-bit, wraps 7->0).
  - Each synced sclk falling edge: tx_shift shifts left by 1. After the 8th falling edge in RX_HIGH, tx_shift loads o_counter[7:0].
  - RX_HIGH, 8th rising edge: hi_reg = {rx_shift[4:0],mosi_sync}[5:0]. pad_err = (received bits [7:6] != 0). -> RX_LOW.
  - RX_LOW, 8th rising edge: lo_reg = complete byte. -> WAIT_SS.
  - WAIT_SS: any further sclk rising edge sets overrun.
  - WAIT_SS, synced ss rising edge:
    - If pad_err=0 and overrun=0: o_counter={hi_reg,lo_reg} and o_valid=1 for exactly one cycle, registered in the cycle after the edge is detected.
    - Otherwise: o_frame_err=1 for one cycle and o_counter holds.
    - Either way -> IDLE.
  - RX_HIGH or RX_LOW, synced ss rising edge (short frame): o_frame_err pulse, o_counter holds, -> IDLE.
- Latency from ss pin rise to o_valid: SYNC_STAGES+2 clk cycles.
- o_valid and o_frame_err are never high in the same cycle.
- In IDLE, miso=0 and sclk edges are ignored.
- An sclk edge and an ss rising edge detected in the same cycle: the ss edge takes priority and the bit is discarded.
- Reset mid-frame aborts the frame with no o_valid or o_frame_err pulse. o_counter returns to 0.

Test Plan:
- Frame bytes 0x12, 0x34, then ss high -> o_counter=0x1234, one o_valid pulse 4 clk after ss rise, o_frame_err=0.
- Back-to-back frames 0x3F,0xFF then 0x00,0x00 -> o_counter=0x3FFF then 0x0000, two valid pulses. During the second frame, miso shifts out 0x3F then 0xFF.
- Frame 0x40, 0x01 (pad bit set) -> o_frame_err pulse, o_counter unchanged, no o_valid.
- Short frame: ss rises after 11 sclk cycles -> o_frame_err pulse, return to IDLE. A following good frame 0x00,0x07 -> o_counter=0x0007.
- 17 sclk cycles within one ss-low window -> overrun, o_frame_err on ss rise, o_counter unchanged.
- Reset asserted mid-RX_LOW with ss held low, released with ss still low, 8 sclk cycles, then ss high -> no valid/err pulses. The next full frame 0x01,0x00 -> o_counter=0x0100.

Source files
------------

// File: rtl/spi_slave_counter_rx.sv
// SPI mode-0 slave that rebuilds the 14-bit counter from a 2-byte SS frame.
// The committed value is looped back on MISO during the next frame.
module spi_slave_counter_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             ss,
  output logic             miso,
  output logic [CNT_W-1:0] o_counter,
  output logic             o_valid,
  output logic             o_frame_err,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    RX_HIGH,
    RX_LOW,
    WAIT_SS
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_flush;
  logic                   r_sclk_d;
  logic                   r_ss_d;
  logic                   r_armed;

  logic w_sclk_s;
  logic w_mosi_s;
  logic w_ss_s;
  logic w_sync_ok;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_ss_rise;
  logic w_ss_fall;

  state_t r_state;
  state_t w_state_nxt;

  logic       w_start;
  logic       w_rx_bit;
  logic       w_tx_edge;
  logic       w_commit;
  logic       w_reject;

  logic [2:0] r_bit_cnt;
  logic [3:0] r_fall_cnt;
  logic [7:0] r_rx_shift;
  logic [7:0] r_tx_shift;
  logic [5:0] r_hi;
  logic [7:0] r_lo;
  logic       r_pad_err;
  logic       r_overrun;
  logic       r_commit;
  logic       r_reject;

  assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss_s    = r_ss_sync[SYNC_STAGES-1];
  assign w_sync_ok = r_flush[SYNC_STAGES-1];

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_ss_rise   = w_ss_s & ~r_ss_d;
  assign w_ss_fall   = ~w_ss_s & r_ss_d;

  // Input synchronizers; r_flush marks when the last stage holds a real
  // pin sample rather than its reset value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_sync   <= '1;
      r_flush     <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
      r_flush     <= {r_flush[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Delayed copies for edge detection, and the arm flag that blocks a
  // frame whose ss fall happened before or across reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_d <= 1'b0;
      r_ss_d   <= 1'b1;
      r_armed  <= 1'b0;
    end else begin
      r_sclk_d <= w_sclk_s;
      r_ss_d   <= w_ss_s;
      if (w_sync_ok && w_ss_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle strobes; an ss rise wins over any sclk edge.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_rx_bit    = 1'b0;
    w_tx_edge   = 1'b0;
    w_commit    = 1'b0;
    w_reject    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ss_fall && r_armed) begin
          w_state_nxt = RX_HIGH;
          w_start     = 1'b1;
        end
      end
      RX_HIGH, RX_LOW: begin
        if (w_ss_rise) begin
          w_state_nxt = IDLE;
          w_reject    = 1'b1;
        end else begin
          w_rx_bit  = w_sclk_rise;
          w_tx_edge = w_sclk_fall;
          if (w_sclk_rise && r_bit_cnt == 3'd7) begin
            w_state_nxt = (r_state == RX_HIGH) ? RX_LOW : WAIT_SS;
          end
        end
      end
      WAIT_SS: begin
        if (w_ss_rise) begin
          w_state_nxt = IDLE;
          if (r_pad_err || r_overrun) begin
            w_reject = 1'b1;
          end else begin
            w_commit = 1'b1;
          end
        end else begin
          w_tx_edge = w_sclk_fall;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Receive and loopback shift registers plus frame error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt  <= '0;
      r_fall_cnt <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_pad_err  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_start) begin
        r_bit_cnt  <= '0;
        r_fall_cnt <= '0;
        r_pad_err  <= 1'b0;
        r_overrun  <= 1'b0;
        r_tx_shift <= {2'b00, o_counter[13:8]};
      end
      if (w_rx_bit) begin
        r_rx_shift <= {r_rx_shift[6:0], w_mosi_s};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          if (r_state == RX_HIGH) begin
            r_hi      <= {r_rx_shift[4:0], w_mosi_s};
            r_pad_err <= |r_rx_shift[6:5];
          end else begin
            r_lo <= {r_rx_shift[6:0], w_mosi_s};
          end
        end
      end
      if (w_tx_edge) begin
        if (r_fall_cnt == 4'd7) begin
          r_tx_shift <= o_counter[7:0];
        end else begin
          r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        end
        if (r_fall_cnt != 4'd15) begin
          r_fall_cnt <= r_fall_cnt + 4'd1;
        end
      end
      if (r_state == WAIT_SS && w_sclk_rise && !w_ss_rise) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Frame outcome is staged one cycle, then drives the output pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_commit    <= 1'b0;
      r_reject    <= 1'b0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_counter   <= '0;
    end else begin
      r_commit    <= w_commit;
      r_reject    <= w_reject;
      o_valid     <= r_commit;
      o_frame_err <= r_reject;
      if (r_commit) begin
        o_counter <= {r_hi, r_lo};
      end
    end
  end

  assign miso   = (r_state != IDLE) & r_tx_shift[7];
  assign o_busy = (r_state != IDLE);

endmodule

// File: tb/tb_spi_slave_counter_rx.sv
// Directed bench for spi_slave_counter_rx.
// Drives mode-0 SPI frames and checks commits, errors and loopback.
module tb_spi_slave_counter_rx;

  localparam int HP = 8;

  logic        clk;
  logic        reset;
  logic        sclk;
  logic        mosi;
  logic        ss;
  logic        miso;
  logic [13:0] o_counter;
  logic        o_valid;
  logic        o_frame_err;
  logic        o_busy;

  int n_cmp;
  int n_bad;
  int n_valid;
  int n_err;
  int n_both;

  spi_slave_counter_rx #(
    .SYNC_STAGES(2),
    .CNT_W(14)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sclk(sclk),
    .mosi(mosi),
    .ss(ss),
    .miso(miso),
    .o_counter(o_counter),
    .o_valid(o_valid),
    .o_frame_err(o_frame_err),
    .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (o_valid) n_valid++;
      if (o_frame_err) n_err++;
      if (o_valid && o_frame_err) n_both++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nb,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nb; i++) begin
      mosi = tx[7 - (i % 8)];
      tick(HP);
      rx[7 - (i % 8)] = miso;
      sclk = 1'b1;
      tick(HP);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] hi, input logic [7:0] lo,
                       output logic [7:0] rh, output logic [7:0] rl);
    ss = 1'b0;
    tick(HP);
    spi_bits(hi, 8, rh);
    spi_bits(lo, 8, rl);
    tick(HP);
    ss = 1'b1;
  endtask

  logic [7:0] rh;
  logic [7:0] rl;
  int v0;
  int e0;
  int lat;

  initial begin
    n_cmp = 0; n_bad = 0;
    n_valid = 0; n_err = 0; n_both = 0;
    reset = 1'b1; sclk = 1'b0; mosi = 1'b0; ss = 1'b1;
    tick(3);
    chk("rst_cnt", 32'(o_counter), 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_err", 32'(o_frame_err), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_miso", 32'(miso), 32'h0);
    reset = 1'b0;
    tick(6);

    // Good frame 0x1234 with latency measurement.
    v0 = n_valid; e0 = n_err;
    ss = 1'b0;
    tick(HP);
    chk("busy_in_frame", 32'(o_busy), 32'h1);
    spi_bits(8'h12, 8, rh);
    spi_bits(8'h34, 8, rl);
    tick(HP);
    @(posedge clk);
    #1 ss = 1'b1;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (o_valid) break;
    end
    chk("lat_valid", 32'(lat), 32'd4);
    tick(8);
    chk("cnt_1234", 32'(o_counter), 32'h1234);
    chk("v_1234", 32'(n_valid - v0), 32'd1);
    chk("e_1234", 32'(n_err - e0), 32'd0);
    chk("miso_hi0", 32'(rh), 32'h00);
    chk("miso_lo0", 32'(rl), 32'h00);
    chk("busy_idle", 32'(o_busy), 32'h0);

    // Pad bit set: rejected, counter holds.
    v0 = n_valid; e0 = n_err;
    frame(8'h40, 8'h01, rh, rl);
    tick(10);
    chk("e_pad", 32'(n_err - e0), 32'd1);
    chk("v_pad", 32'(n_valid - v0), 32'd0);
    chk("cnt_pad", 32'(o_counter), 32'h1234);
    chk("miso_hi_pad", 32'(rh), 32'h12);
    chk("miso_lo_pad", 32'(rl), 32'h34);

    // Back-to-back frames; second one loops back 0x3FFF.
    v0 = n_valid; e0 = n_err;
    frame(8'h3F, 8'hFF, rh, rl);
    tick(10);
    chk("cnt_3fff", 32'(o_counter), 32'h3FFF);
    frame(8'h00, 8'h00, rh, rl);
    tick(10);
    chk("cnt_0000", 32'(o_counter), 32'h0000);
    chk("v_b2b", 32'(n_valid - v0), 32'd2);
    chk("e_b2b", 32'(n_err - e0), 32'd0);
    chk("miso_hi_3f", 32'(rh), 32'h3F);
    chk("miso_lo_ff", 32'(rl), 32'hFF);

    // Short frame of 11 sclk cycles.
    v0 = n_valid; e0 = n_err;
    ss = 1'b0;
    tick(HP);
    spi_bits(8'h00, 8, rh);
    spi_bits(8'hE0, 3, rl);
    tick(HP);
    ss = 1'b1;
    tick(10);
    chk("e_short", 32'(n_err - e0), 32'd1);
    chk("v_short", 32'(n_valid - v0), 32'd0);
    chk("busy_short", 32'(o_busy), 32'h0);
    frame(8'h00, 8'h07, rh, rl);
    tick(10);
    chk("cnt_0007", 32'(o_counter), 32'h0007);

    // Overrun: 17 sclk cycles in one ss window.
    v0 = n_valid; e0 = n_err;
    ss = 1'b0;
    tick(HP);
    spi_bits(8'h12, 8, rh);
    spi_bits(8'h34, 8, rl);
    spi_bits(8'h80, 1, rl);
    tick(HP);
    ss = 1'b1;
    tick(10);
    chk("e_ovr", 32'(n_err - e0), 32'd1);
    chk("v_ovr", 32'(n_valid - v0), 32'd0);
    chk("cnt_ovr", 32'(o_counter), 32'h0007);

    // Reset in the middle of the low byte, released with ss low.
    ss = 1'b0;
    tick(HP);
    spi_bits(8'h01, 8, rh);
    spi_bits(8'hA0, 3, rl);
    reset = 1'b1;
    tick(3);
    chk("cnt_midrst", 32'(o_counter), 32'h0);
    chk("busy_midrst", 32'(o_busy), 32'h0);
    reset = 1'b0;
    tick(4);
    v0 = n_valid; e0 = n_err;
    spi_bits(8'h5A, 8, rl);
    tick(HP);
    chk("busy_unarmed", 32'(o_busy), 32'h0);
    ss = 1'b1;
    tick(10);
    chk("v_unarmed", 32'(n_valid - v0), 32'd0);
    chk("e_unarmed", 32'(n_err - e0), 32'd0);
    chk("cnt_unarmed", 32'(o_counter), 32'h0);
    frame(8'h01, 8'h00, rh, rl);
    tick(10);
    chk("cnt_0100", 32'(o_counter), 32'h0100);
    chk("v_0100", 32'(n_valid - v0), 32'd1);

    chk("valid_err_overlap", 32'(n_both), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
